// File: rtl/pl_reset_pkg.sv
// pl_reset_pkg: state encodings, default timing constants and the lock timeout limit
package pl_reset_pkg;

    localparam logic [2:0] ST_RST         = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK   = 3'd1;
    localparam logic [2:0] ST_HOLD_IC     = 3'd2;
    localparam logic [2:0] ST_HOLD_PERIPH = 3'd3;
    localparam logic [2:0] ST_RUN         = 3'd4;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_FILTER = 8;
    localparam int DEF_IC_HOLD     = 16;
    localparam int DEF_PERIPH_HOLD = 16;
    localparam int DEF_CNT_W       = 16;

    localparam logic [15:0] LOCK_TIMEOUT_LIMIT = 16'd4095;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pl_reset_sequencer_sync.sv
// pl_sync_bit: multi-flop synchroniser with asynchronous active-low clear
module pl_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;

    // shift the asynchronous input one stage per clock
    always_comb sync_d = {sync_q[STAGES-2:0], d};

    // synchroniser flops, cleared by the async reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else sync_q <= sync_d;

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pl_reset_sequencer.sv
// pl_reset_sequencer: staged PL reset release gated on a filtered clk_wizard lock (optional LOCK_TIMEOUT_EN)
module pl_reset_sequencer
    import pl_reset_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_FILTER = DEF_LOCK_FILTER,
    parameter int IC_HOLD     = DEF_IC_HOLD,
    parameter int PERIPH_HOLD = DEF_PERIPH_HOLD,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             pl_clk0,
    input  logic             pl_resetn,
    input  logic             locked,
    input  logic             soft_rst_req,
    output logic             interconnect_aresetn,
    output logic             peripheral_aresetn,
    output logic             seq_ready,
    output logic [2:0]       seq_state,
    output logic [CNT_W-1:0] run_cnt,
    output logic [7:0]       lock_loss_cnt,
    output logic             lock_timeout
);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int HW = $clog2(max2(IC_HOLD, PERIPH_HOLD) + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0] IC_LAST   = HW'(IC_HOLD - 1);
    localparam logic [HW-1:0] PH_LAST   = HW'(PERIPH_HOLD - 1);

    logic lk, srq, good;
    logic [2:0]       state_q, state_d;
    logic [FW-1:0]    filt_q, filt_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             ic_q, ic_d, periph_q, periph_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [7:0]       loss_q, loss_d;

    pl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lk (.clk(pl_clk0), .rst_n(pl_resetn), .d(locked), .q(lk));
    pl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_srq (.clk(pl_clk0), .rst_n(pl_resetn), .d(soft_rst_req), .q(srq));

    assign good = lk & ~srq;

    // sequencing FSM: any lock loss or soft request falls back to WAIT_LOCK
    always_comb begin
        state_d = state_q;
        filt_d  = '0;
        hold_d  = '0;
        case (state_q)
            ST_RST: state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                filt_d  = good ? filt_q + FW'(1) : '0;
                if (good && filt_q == FILT_LAST) begin
                    state_d = ST_HOLD_IC;
                    filt_d  = '0;
                end
            end
            ST_HOLD_IC: begin
                hold_d  = hold_q + HW'(1);
                if (!good) state_d = ST_WAIT_LOCK;
                else if (hold_q == IC_LAST) state_d = ST_HOLD_PERIPH;
                if (state_d != state_q) hold_d = '0;
            end
            ST_HOLD_PERIPH: begin
                hold_d  = hold_q + HW'(1);
                if (!good) state_d = ST_WAIT_LOCK;
                else if (hold_q == PH_LAST) state_d = ST_RUN;
                if (state_d != state_q) hold_d = '0;
            end
            ST_RUN: state_d = good ? ST_RUN : ST_WAIT_LOCK;
            default: state_d = ST_WAIT_LOCK;
        endcase
    end

    // registered reset outputs and saturating monitor counters
    always_comb begin
        ic_d     = (state_d == ST_HOLD_PERIPH) || (state_d == ST_RUN);
        periph_d = (state_d == ST_RUN);
        run_d    = (state_q == ST_RUN) ? (&run_q ? run_q : run_q + CNT_W'(1))
                 : (state_d == ST_RUN) ? '0 : run_q;
        loss_d   = (state_q == ST_RUN && !lk && loss_q != 8'hFF) ? loss_q + 8'd1 : loss_q;
    end

    // state and output flops, all cleared asynchronously
    always_ff @(posedge pl_clk0 or negedge pl_resetn)
        if (!pl_resetn) begin
            state_q  <= ST_RST;
            filt_q   <= '0;
            hold_q   <= '0;
            ic_q     <= 1'b0;
            periph_q <= 1'b0;
            run_q    <= '0;
            loss_q   <= '0;
        end else begin
            state_q  <= state_d;
            filt_q   <= filt_d;
            hold_q   <= hold_d;
            ic_q     <= ic_d;
            periph_q <= periph_d;
            run_q    <= run_d;
            loss_q   <= loss_d;
        end

`ifdef LOCK_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        to_q, to_d;

    // count consecutive WAIT_LOCK cycles and latch the timeout flag
    always_comb begin
        to_cnt_d = (state_d != ST_WAIT_LOCK || state_q != ST_WAIT_LOCK) ? '0
                 : to_cnt_q + {15'd0, ~&to_cnt_q};
        to_d     = to_q | (to_cnt_d == LOCK_TIMEOUT_LIMIT);
    end

    // timeout counter and sticky flag flops
    always_ff @(posedge pl_clk0 or negedge pl_resetn)
        if (!pl_resetn) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_q     <= to_d;
        end

    assign lock_timeout = to_q;
`else
    assign lock_timeout = 1'b0;
`endif

    assign interconnect_aresetn = ic_q;
    assign peripheral_aresetn   = periph_q;
    assign seq_ready            = periph_q;
    assign seq_state            = state_q;
    assign run_cnt              = run_q;
    assign lock_loss_cnt        = loss_q;
endmodule

// File: tb/tb_pl_reset_sequencer.sv
// tb_pl_reset_sequencer: directed scenarios checked against a run-length model of the release sequence
module tb_pl_reset_sequencer;
    localparam int SS  = 2;
    localparam int LF  = 8;
    localparam int ICH = 16;
    localparam int PH  = 16;
    localparam int CW  = 16;
`ifdef LOCK_TIMEOUT_EN
    localparam int TO_EN = 1;
`else
    localparam int TO_EN = 0;
`endif

    logic          pl_clk0 = 1'b0;
    logic          pl_resetn, locked, soft_rst_req;
    logic          interconnect_aresetn, peripheral_aresetn, seq_ready, lock_timeout;
    logic [2:0]    seq_state;
    logic [CW-1:0] run_cnt;
    logic [7:0]    lock_loss_cnt;

    int tests = 0;
    int fails = 0;

    // model: m_t counts consecutive good (synced lock high, no soft request) cycles
    int m_t, m_state, m_run, m_loss, m_wc, m_edge, m_prev;
    bit m_to, m_lk, m_sq;
    bit lq[$];
    bit sq[$];

    pl_reset_sequencer #(.SYNC_STAGES(SS), .LOCK_FILTER(LF), .IC_HOLD(ICH), .PERIPH_HOLD(PH), .CNT_W(CW)) dut (
        .pl_clk0(pl_clk0), .pl_resetn(pl_resetn), .locked(locked), .soft_rst_req(soft_rst_req),
        .interconnect_aresetn(interconnect_aresetn), .peripheral_aresetn(peripheral_aresetn),
        .seq_ready(seq_ready), .seq_state(seq_state), .run_cnt(run_cnt),
        .lock_loss_cnt(lock_loss_cnt), .lock_timeout(lock_timeout)
    );

    always #5 pl_clk0 = ~pl_clk0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_state = 0; m_run = 0; m_loss = 0; m_wc = 0; m_edge = 0; m_to = 0;
        lq = {}; sq = {};
        repeat (SS) begin lq.push_back(1'b0); sq.push_back(1'b0); end
    endtask

    // reference model: the state is a pure function of the good-cycle run length
    initial begin
        model_reset();
        forever begin
            @(posedge pl_clk0 or negedge pl_resetn);
            if (!pl_resetn) model_reset();
            else begin
                m_lk = lq.pop_front();
                m_sq = sq.pop_front();
                lq.push_back(locked);
                sq.push_back(soft_rst_req);
                m_prev = m_state;
                m_edge++;
                if (m_prev == 4 && !m_lk && m_loss < 255) m_loss++;
                m_t = (m_prev == 0 || !m_lk || m_sq) ? 0 : (m_t < LF + ICH + PH ? m_t + 1 : m_t);
                m_state = m_t < LF ? 1 : m_t < LF + ICH ? 2 : m_t < LF + ICH + PH ? 3 : 4;
                m_run = m_prev == 4 ? (m_run < 2**CW - 1 ? m_run + 1 : m_run) : m_state == 4 ? 0 : m_run;
                m_wc = m_state == 1 ? m_wc + 1 : 0;
                if (TO_EN != 0 && m_wc == 4096) m_to = 1'b1;
            end
        end
    end

    // per-cycle compare on the falling edge
    initial forever begin
        @(negedge pl_clk0);
        check("state", 32'(seq_state), m_state);
        check("ic_aresetn", 32'(interconnect_aresetn), 32'(m_state >= 3));
        check("periph_aresetn", 32'(peripheral_aresetn), 32'(m_state == 4));
        check("seq_ready", 32'(seq_ready), 32'(m_state == 4));
        check("run_cnt", 32'(run_cnt), m_run);
        check("lock_loss_cnt", 32'(lock_loss_cnt), m_loss);
        check("lock_timeout", 32'(lock_timeout), 32'(m_to));
    end

    task automatic at(input int e);
        int guard = 0;
        while (m_edge < e && guard < 20000) begin
            @(posedge pl_clk0);
            #2;
            guard++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        pl_resetn = 1'b0; locked = 1'b0; soft_rst_req = 1'b0;
        repeat (3) @(posedge pl_clk0);
        #2;
        check("rst_state", 32'(seq_state), 0);
        check("rst_ic", 32'(interconnect_aresetn), 0);
        check("rst_periph", 32'(peripheral_aresetn), 0);
        check("rst_run_cnt", 32'(run_cnt), 0);
        // scenario 1: locked steady from reset release
        locked = 1'b1; pl_resetn = 1'b1;
        at(25); check("s1_ic_low", 32'(interconnect_aresetn), 0);
        at(26); check("s1_ic_high", 32'(interconnect_aresetn), 1); check("s1_state_hp", 32'(seq_state), 3);
        at(41); check("s1_periph_low", 32'(peripheral_aresetn), 0);
        at(42); check("s1_periph_high", 32'(peripheral_aresetn), 1); check("s1_ready", 32'(seq_ready), 1);
        check("s1_state_run", 32'(seq_state), 4); check("s1_run0", 32'(run_cnt), 0);
        // scenario 2: lock glitch restarts the filter
        pl_resetn = 1'b0; locked = 1'b0;
        repeat (2) @(posedge pl_clk0);
        #2;
        pl_resetn = 1'b1; locked = 1'b1;
        at(5); locked = 1'b0;
        at(6); locked = 1'b1;
        at(47); check("s2_periph_low", 32'(peripheral_aresetn), 0);
        at(48); check("s2_periph_high", 32'(peripheral_aresetn), 1);
        // scenario 3: one-cycle lock drop in RUN
        at(148); check("s3_run100", 32'(run_cnt), 100);
        locked = 1'b0;
        at(149); locked = 1'b1; check("s3_still_run", 32'(peripheral_aresetn), 1);
        at(150); check("s3_still_run2", 32'(peripheral_aresetn), 1);
        at(151); check("s3_periph_drop", 32'(peripheral_aresetn), 0); check("s3_ic_drop", 32'(interconnect_aresetn), 0);
        check("s3_state_wait", 32'(seq_state), 1); check("s3_loss1", 32'(lock_loss_cnt), 1);
        check("s3_run_hold", 32'(run_cnt), 103);
        at(190); check("s3_state_hp", 32'(seq_state), 3);
        at(191); check("s3_rerun", 32'(seq_state), 4); check("s3_run_restart", 32'(run_cnt), 0);
        // scenario 4: soft request from RUN, then a long one during HOLD_PERIPH
        soft_rst_req = 1'b1;
        at(192); soft_rst_req = 1'b0;
        at(193); check("s4_run", 32'(seq_state), 4);
        at(194); check("s4_wait", 32'(seq_state), 1); check("s4_loss_same", 32'(lock_loss_cnt), 1);
        at(220); check("s4_hp", 32'(seq_state), 3); soft_rst_req = 1'b1;
        at(222); check("s4_ic_high", 32'(interconnect_aresetn), 1);
        at(223); check("s4_ic_fall", 32'(interconnect_aresetn), 0); check("s4_loss_same2", 32'(lock_loss_cnt), 1);
        at(230); soft_rst_req = 1'b0;
        at(271); check("s4_hp_again", 32'(seq_state), 3);
        at(272); check("s4_run_again", 32'(seq_state), 4);
        // scenario 5: async reset pulse in HOLD_IC
        pl_resetn = 1'b0;
        repeat (2) @(posedge pl_clk0);
        #2;
        pl_resetn = 1'b1;
        at(15); check("s5_hold_ic", 32'(seq_state), 2);
        pl_resetn = 1'b0; locked = 1'b0;
        #1;
        check("s5_async_state", 32'(seq_state), 0);
        check("s5_async_ic", 32'(interconnect_aresetn), 0);
        check("s5_async_loss", 32'(lock_loss_cnt), 0);
        #1;
        pl_resetn = 1'b1;
        // scenario 6: long lock absence
        at(4095); check("s6_to_before", 32'(lock_timeout), 0);
        at(4096); check("s6_to_at", 32'(lock_timeout), TO_EN);
        at(5000); locked = 1'b1;
        at(5042); check("s6_release", 32'(seq_ready), 1); check("s6_to_sticky", 32'(lock_timeout), TO_EN);
        at(5045);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
